// File: rtl/aibcr3_sync_debounce.sv
// Glitch filter behind the AIB 3-flop synchronizer: qualifies D for FILT_CYC cycles before moving Q.
// Optional build macro AIBCR3_DEBOUNCE_GLITCH_CNT_EN enables the saturating aborted-qualification counter.
module aibcr3_sync_debounce #(
   parameter int   FILT_CYC = 4,
   parameter int   CNT_W    = 4,
   parameter logic RST_VAL  = 1'b0
) (
   input  logic       CP,
   input  logic       CDN,
   input  logic       D,
   input  logic       en,
   output logic       Q,
   output logic       rise_p,
   output logic       fall_p,
   output logic       busy,
   output logic [7:0] glitch_cnt
);

   generate
      if (FILT_CYC < 2 || FILT_CYC > (2**CNT_W) - 1) begin : g_bad_cfg
         $error("aibcr3_sync_debounce: FILT_CYC out of range for CNT_W");
      end
   endgenerate

   typedef enum logic {STABLE, QUAL} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_CYC - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // cnt counts cycles D has differed from Q; Q flips on the cycle cnt reaches LAST.
   always_ff @(posedge CP) begin
      if (!CDN) begin
         state  <= STABLE;
         cnt    <= '0;
         Q      <= RST_VAL;
         rise_p <= 1'b0;
         fall_p <= 1'b0;
         busy   <= 1'b0;
      end else begin
         rise_p <= 1'b0;
         fall_p <= 1'b0;
         case (state)
            STABLE: begin
               if (en && (D != Q)) begin
                  state <= QUAL;
                  cnt   <= CNT_W'(1);
                  busy  <= 1'b1;
               end else begin
                  cnt  <= '0;
                  busy <= 1'b0;
               end
            end
            QUAL: begin
               if (!en || (D == Q)) begin
                  state <= STABLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == LAST) begin
                  Q      <= D;
                  rise_p <= D;
                  fall_p <= ~D;
                  state  <= STABLE;
                  cnt    <= '0;
                  busy   <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AIBCR3_DEBOUNCE_GLITCH_CNT_EN
   logic       glitch_evt;
   logic [7:0] gcnt;

   // Only a D==Q abort counts as a glitch; an en-driven abort is not the input's fault.
   assign glitch_evt = (state == QUAL) && en && (D == Q);

   always_ff @(posedge CP) begin
      if (!CDN) begin
         gcnt <= 8'h00;
      end else if (glitch_evt && (gcnt != 8'hFF)) begin
         gcnt <= gcnt + 8'h01;
      end
   end

   assign glitch_cnt = gcnt;
`else
   assign glitch_cnt = 8'h00;
`endif

endmodule
